// File: rtl/tensor_mma_pkg.sv
// Shared types and constants for the warp-level integer matrix-multiply-accumulate unit.
package tensor_mma_pkg;

    typedef enum logic [1:0] {
        OP_LOAD_B = 2'd0,
        OP_MMA    = 2'd1,
        OP_CLEAR  = 2'd2,
        OP_NOP    = 2'd3
    } op_e;

    localparam int PIPE_LAT = 3;

    // Index width that never collapses to zero bits for single-entry structures.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tensor_mma_group.sv
// One thread group's TG x TG multiply array (stage 1) and per-column adder tree plus D (stage 2).
module tensor_mma_group
    import tensor_mma_pkg::*;
#(
    parameter int TG   = 4,
    parameter int XLEN = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [TG*XLEN-1:0]    a_in,
    input  logic [TG*TG*XLEN-1:0] b_in,
    input  logic [TG*XLEN-1:0]    d_in,
    output logic [TG*XLEN-1:0]    sum_out
);

    // Product k,j sits at (k*TG + j)*XLEN, matching the row-major B tile layout.
    logic [TG*TG*XLEN-1:0] prod_q, prod_d;
    logic [TG*XLEN-1:0]    acc_q, acc_d;
    logic [TG*XLEN-1:0]    sum_q, sum_d;
    logic [XLEN-1:0]       col_s;

    // Next-state for the product, accumulator-operand and sum registers.
    always_comb begin
        prod_d = prod_q;
        acc_d  = acc_q;
        sum_d  = sum_q;
        col_s  = '0;
        if (en) begin
            for (int k = 0; k < TG; k++) begin
                for (int j = 0; j < TG; j++) begin
                    prod_d[(k*TG + j)*XLEN +: XLEN] =
                        a_in[k*XLEN +: XLEN] * b_in[(k*TG + j)*XLEN +: XLEN];
                end
            end
            acc_d = d_in;
            for (int j = 0; j < TG; j++) begin
                col_s = acc_q[j*XLEN +: XLEN];
                for (int k = 0; k < TG; k++) begin
                    col_s = col_s + prod_q[(k*TG + j)*XLEN +: XLEN];
                end
                sum_d[j*XLEN +: XLEN] = col_s;
            end
        end else begin
            prod_d = prod_q;
        end
    end

    // Stage 1 and stage 2 registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prod_q <= '0;
            acc_q  <= '0;
            sum_q  <= '0;
        end else begin
            prod_q <= prod_d;
            acc_q  <= acc_d;
            sum_q  <= sum_d;
        end
    end

    assign sum_out = sum_q;

endmodule

// File: rtl/tensor_mma_unit.sv
// Per-warp integer MMA unit: B-tile storage with row counters, three-stage C = A*B + D
// pipeline and a stall-all valid/ready output stage.
module tensor_mma_unit
    import tensor_mma_pkg::*;
#(
    parameter int THREAD_GROUP_SIZE = 4,
    parameter int NUM_THREADS       = 16,
    parameter int XLEN              = 32,
    parameter int NUM_WARPS         = 8,
    parameter int NUM_REGS          = 32,
    localparam int WW = idx_w(NUM_WARPS),
    localparam int RW = idx_w(NUM_REGS)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        valid_in,
    output logic                        ready_in,
    input  logic [1:0]                  op_in,
    input  logic [WW-1:0]               wid_in,
    input  logic [RW-1:0]               rd_in,
    input  logic [NUM_THREADS*XLEN-1:0] rs1_data,
    input  logic [NUM_THREADS*XLEN-1:0] rs3_data,
    output logic                        valid_out,
    input  logic                        ready_out,
    output logic [NUM_THREADS*XLEN-1:0] data_out,
    output logic [RW-1:0]               rd_out,
    output logic [WW-1:0]               wid_out,
    output logic                        err_out,
    output logic [NUM_WARPS-1:0]        b_ready_mask
);

    localparam int TG = THREAD_GROUP_SIZE;
    localparam int NG = NUM_THREADS / TG;
    localparam int CW = idx_w(TG);
    localparam int DW = NUM_THREADS * XLEN;
    localparam int BW = NUM_THREADS * TG * XLEN;

    typedef struct packed {
        logic          valid;
        logic          err;
        logic [WW-1:0] wid;
        logic [RW-1:0] rd;
    } meta_t;

    typedef struct packed {
        meta_t         meta;
        logic [DW-1:0] data;
    } stage_t;

    // Per warp, element (g, k, j) of the tiles lives at ((g*TG + k)*TG + j)*XLEN.
    logic [BW-1:0]        b_q [NUM_WARPS];
    logic [BW-1:0]        b_d [NUM_WARPS];
    logic [CW-1:0]        row_cnt_q [NUM_WARPS];
    logic [CW-1:0]        row_cnt_d [NUM_WARPS];
    logic [NUM_WARPS-1:0] mask_q, mask_d;

    meta_t  s1_q, s1_d, s2_q, s2_d;
    stage_t s3_q, s3_d;

    logic          adv_s;
    logic          accept_s;
    op_e           op_s;
    logic [BW-1:0] b_rd_s;
    logic [DW-1:0] sum_s;

    assign op_s     = op_e'(op_in);
    assign adv_s    = !(s3_q.meta.valid && !ready_out);
    assign accept_s = valid_in && adv_s;
    assign b_rd_s   = b_q[wid_in];

    // Tile writes, row-counter stepping and tile-complete tracking.
    always_comb begin
        b_d       = b_q;
        row_cnt_d = row_cnt_q;
        mask_d    = mask_q;
        if (accept_s) begin
            case (op_s)
                OP_LOAD_B: begin
                    for (int g = 0; g < NG; g++) begin
                        for (int j = 0; j < TG; j++) begin
                            b_d[wid_in][((g*TG + int'(row_cnt_q[wid_in]))*TG + j)*XLEN +: XLEN] =
                                rs1_data[(g*TG + j)*XLEN +: XLEN];
                        end
                    end
                    if (row_cnt_q[wid_in] == CW'(TG - 1)) begin
                        row_cnt_d[wid_in] = '0;
                        mask_d[wid_in]    = 1'b1;
                    end else begin
                        row_cnt_d[wid_in] = row_cnt_q[wid_in] + CW'(1);
                    end
                end
                OP_CLEAR: begin
                    row_cnt_d[wid_in] = '0;
                    mask_d[wid_in]    = 1'b0;
                end
                default: begin
                    mask_d = mask_q;
                end
            endcase
        end else begin
            mask_d = mask_q;
        end
    end

    // Tile storage, row counters and ready mask.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                b_q[w]       <= '0;
                row_cnt_q[w] <= '0;
            end
            mask_q <= '0;
        end else begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                b_q[w]       <= b_d[w];
                row_cnt_q[w] <= row_cnt_d[w];
            end
            mask_q <= mask_d;
        end
    end

    // The whole pipeline advances together; a blocked output freezes every stage.
    always_comb begin
        s1_d = s1_q;
        s2_d = s2_q;
        s3_d = s3_q;
        if (adv_s) begin
            s1_d.valid = accept_s && (op_s == OP_MMA);
            s1_d.err   = !mask_q[wid_in];
            s1_d.wid   = wid_in;
            s1_d.rd    = rd_in;
            s2_d       = s1_q;
            s3_d.meta  = s2_q;
            s3_d.data  = sum_s;
        end else begin
            s3_d = s3_q;
        end
    end

    // Pipeline metadata and output register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    for (genvar g = 0; g < NG; g++) begin : g_group
        tensor_mma_group #(
            .TG   (TG),
            .XLEN (XLEN)
        ) u_group (
            .clk     (clk),
            .reset   (reset),
            .en      (adv_s),
            .a_in    (rs1_data[g*TG*XLEN +: TG*XLEN]),
            .b_in    (b_rd_s[g*TG*TG*XLEN +: TG*TG*XLEN]),
            .d_in    (rs3_data[g*TG*XLEN +: TG*XLEN]),
            .sum_out (sum_s[g*TG*XLEN +: TG*XLEN])
        );
    end

    assign ready_in     = adv_s;
    assign valid_out    = s3_q.meta.valid;
    assign err_out      = s3_q.meta.err;
    assign wid_out      = s3_q.meta.wid;
    assign rd_out       = s3_q.meta.rd;
    assign data_out     = s3_q.data;
    assign b_ready_mask = mask_q;

endmodule

// File: tb/tb_tensor_mma_unit.sv
// Randomised bench for tensor_mma_unit against an array-based matrix model of the B tiles.
module tb_tensor_mma_unit;
    import tensor_mma_pkg::*;

    localparam int TG = 2;
    localparam int NT = 4;
    localparam int NW = 2;
    localparam int XL = 32;
    localparam int NR = 32;
    localparam int NG = NT / TG;
    localparam int DW = NT * XL;

    logic          clk = 1'b0;
    logic          reset;
    logic          valid_in;
    logic          ready_in;
    logic [1:0]    op_in;
    logic [0:0]    wid_in;
    logic [4:0]    rd_in;
    logic [DW-1:0] rs1_data;
    logic [DW-1:0] rs3_data;
    logic          valid_out;
    logic          ready_out;
    logic [DW-1:0] data_out;
    logic [4:0]    rd_out;
    logic [0:0]    wid_out;
    logic          err_out;
    logic [NW-1:0] b_ready_mask;

    tensor_mma_unit #(
        .THREAD_GROUP_SIZE (TG),
        .NUM_THREADS       (NT),
        .XLEN              (XL),
        .NUM_WARPS         (NW),
        .NUM_REGS          (NR)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .valid_in     (valid_in),
        .ready_in     (ready_in),
        .op_in        (op_in),
        .wid_in       (wid_in),
        .rd_in        (rd_in),
        .rs1_data     (rs1_data),
        .rs3_data     (rs3_data),
        .valid_out    (valid_out),
        .ready_out    (ready_out),
        .data_out     (data_out),
        .rd_out       (rd_out),
        .wid_out      (wid_out),
        .err_out      (err_out),
        .b_ready_mask (b_ready_mask)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic [4:0]    rd;
        logic          wid;
        logic          err;
        int            cyc;
    } res_t;

    // Reference state: B[w][g][row][col], next row per warp, tile-complete flags.
    logic [XL-1:0] mb [NW][NG][TG][TG];
    int            mrow [NW];
    logic [NW-1:0] mmask;
    res_t          exp_q[$];
    res_t          obs_q[$];
    res_t          mon_r;
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    bit            rnd_stop;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every completed output handshake.
    always @(negedge clk) begin
        #2;
        if (reset === 1'b0 && valid_out === 1'b1 && ready_out === 1'b1) begin
            mon_r.data = data_out;
            mon_r.rd   = rd_out;
            mon_r.wid  = wid_out[0];
            mon_r.err  = err_out;
            mon_r.cyc  = cyc;
            obs_q.push_back(mon_r);
        end
    end

    function automatic logic [DW-1:0] rand_vec();
        logic [DW-1:0] v;
        for (int i = 0; i < NT; i++) v[i*XL +: XL] = $urandom();
        return v;
    endfunction

    task automatic model_reset();
        for (int w = 0; w < NW; w++) begin
            mrow[w] = 0;
            for (int g = 0; g < NG; g++)
                for (int r = 0; r < TG; r++)
                    for (int j = 0; j < TG; j++) mb[w][g][r][j] = '0;
        end
        mmask = '0;
        exp_q.delete();
    endtask

    task automatic model_accept(input logic [1:0] op, input int w, input logic [4:0] rd,
                                input logic [DW-1:0] a, input logic [DW-1:0] d);
        res_t          r;
        logic [XL-1:0] s;
        case (op)
            2'd0: begin
                for (int g = 0; g < NG; g++)
                    for (int j = 0; j < TG; j++) mb[w][g][mrow[w]][j] = a[(g*TG + j)*XL +: XL];
                if (mrow[w] == TG - 1) begin
                    mrow[w]  = 0;
                    mmask[w] = 1'b1;
                end else begin
                    mrow[w] = mrow[w] + 1;
                end
            end
            2'd1: begin
                r.err = !mmask[w];
                for (int g = 0; g < NG; g++) begin
                    for (int j = 0; j < TG; j++) begin
                        s = d[(g*TG + j)*XL +: XL];
                        for (int k = 0; k < TG; k++) s = s + a[(g*TG + k)*XL +: XL] * mb[w][g][k][j];
                        r.data[(g*TG + j)*XL +: XL] = s;
                    end
                end
                r.rd  = rd;
                r.wid = w[0];
                r.cyc = cyc;
                exp_q.push_back(r);
            end
            2'd2: begin
                mrow[w]  = 0;
                mmask[w] = 1'b0;
            end
            default: ;
        endcase
    endtask

    // Present one instruction until accepted (bounded), then drop valid after the edge.
    task automatic send(input logic [1:0] op, input int w, input logic [4:0] rd,
                        input logic [DW-1:0] a, input logic [DW-1:0] d);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            valid_in = 1'b1; op_in = op; wid_in = w[0]; rd_in = rd; rs1_data = a; rs3_data = d;
            #1;
            if (ready_in === 1'b1) begin
                model_accept(op, w, rd, a, d);
                done = 1'b1;
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL send_accept: accepted=0 required=1 (ready_in stuck low)");
        end else begin
            @(posedge clk);
        end
        #1;
        valid_in = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (obs_q.size() < exp_q.size() && n < 200) begin
            @(negedge clk);
            #3;
            n++;
        end
        checks++;
        if (obs_q.size() < exp_q.size()) begin
            errors++;
            $display("FAIL %s_drain: got %0d results, required %0d", name, obs_q.size(), exp_q.size());
        end
        repeat (4) @(negedge clk);
        #3;
    endtask

    task automatic apply_reset();
        valid_in = 1'b0; op_in = 2'd3; wid_in = '0; rd_in = '0;
        rs1_data = '0; rs3_data = '0; ready_out = 1'b1;
        reset = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        obs_q.delete();
        @(negedge clk);
    endtask

    task automatic test_reset();
        valid_in = 1'b0; op_in = 2'd3; wid_in = '0; rd_in = '0;
        rs1_data = '0; rs3_data = '0; ready_out = 1'b1;
        reset = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (valid_out !== 1'b0 || b_ready_mask !== 2'b00) begin
            errors++;
            $display("FAIL reset_held: valid_out=%b mask=%b required 0/00", valid_out, b_ready_mask);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if ({valid_out, err_out, rd_out, wid_out, b_ready_mask} !== 10'd0 || data_out !== '0) begin
            errors++;
            $display("FAIL reset_state: v=%b e=%b rd=%0d w=%0d m=%b d=%h required all 0",
                     valid_out, err_out, rd_out, wid_out, b_ready_mask, data_out);
        end
        checks++;
        if (ready_in !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: ready_in=%b required 1", ready_in);
        end
    endtask

    task automatic test_load_mma();
        res_t          e, o;
        logic [DW-1:0] want;
        want = {32'd48, 32'd36, 32'd28, 32'd16};
        send(2'd0, 0, 5'd0, {32'd4, 32'd3, 32'd2, 32'd1}, '0);
        send(2'd0, 0, 5'd0, {32'd8, 32'd7, 32'd6, 32'd5}, '0);
        checks++;
        if (b_ready_mask !== 2'b01) begin
            errors++;
            $display("FAIL load_mask: b_ready_mask=%b required 01", b_ready_mask);
        end
        send(2'd1, 0, 5'd5, {32'd0, 32'd2, 32'd1, 32'd1}, {32'd40, 32'd30, 32'd20, 32'd10});
        drain("load_mma");
        checks++;
        if (obs_q.size() != 1 || exp_q.size() != 1) begin
            errors++;
            $display("FAIL load_mma_count: got %0d results, required 1", obs_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (o.data !== want || o.data !== e.data || o.rd !== 5'd5 || o.err !== 1'b0) begin
                errors++;
                $display("FAIL load_mma_result: data=%h rd=%0d err=%b required data=%h rd=5 err=0",
                         o.data, o.rd, o.err, want);
            end
            checks++;
            if (o.cyc - e.cyc != PIPE_LAT) begin
                errors++;
                $display("FAIL load_mma_latency: got %0d cycles, required %0d", o.cyc - e.cyc, PIPE_LAT);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_incomplete();
        res_t e, o;
        apply_reset();
        send(2'd0, 1, 5'd0, rand_vec(), '0);
        checks++;
        if (b_ready_mask !== 2'b00) begin
            errors++;
            $display("FAIL incomplete_mask: b_ready_mask=%b required 00", b_ready_mask);
        end
        send(2'd1, 1, 5'd7, rand_vec(), rand_vec());
        drain("incomplete");
        checks++;
        if (obs_q.size() != 1) begin
            errors++;
            $display("FAIL incomplete_count: got %0d results, required 1", obs_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (o.err !== 1'b1 || o.data !== e.data || o.rd !== e.rd || o.wid !== 1'b1) begin
                errors++;
                $display("FAIL incomplete_result: err=%b data=%h rd=%0d w=%0d required err=1 data=%h rd=%0d w=1",
                         o.err, o.data, o.rd, o.wid, e.data, e.rd);
            end
            checks++;
            if (o.cyc - e.cyc != PIPE_LAT) begin
                errors++;
                $display("FAIL incomplete_latency: got %0d cycles, required %0d", o.cyc - e.cyc, PIPE_LAT);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_backpressure();
        res_t          e, o;
        logic [DW-1:0] held;
        logic [4:0]    held_rd;
        send(2'd0, 0, 5'd0, rand_vec(), '0);
        send(2'd0, 0, 5'd0, rand_vec(), '0);
        ready_out = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++) send(2'd1, 0, 5'(1 + i), rand_vec(), rand_vec());
            end
            begin
                for (int i = 0; i < 20 && valid_out !== 1'b1; i++) begin
                    @(negedge clk);
                    #3;
                end
                held    = data_out;
                held_rd = rd_out;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    #3;
                    checks++;
                    if (valid_out !== 1'b1 || ready_in !== 1'b0) begin
                        errors++;
                        $display("FAIL bp_stall: valid_out=%b ready_in=%b required 1/0", valid_out, ready_in);
                    end
                    checks++;
                    if (data_out !== held || rd_out !== held_rd || rd_out !== 5'd1) begin
                        errors++;
                        $display("FAIL bp_hold: data=%h rd=%0d required data=%h rd=1", data_out, rd_out, held);
                    end
                end
                @(negedge clk);
                ready_out = 1'b1;
            end
        join
        drain("bp");
        checks++;
        if (obs_q.size() != 4) begin
            errors++;
            $display("FAIL bp_count: got %0d results, required 4", obs_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (o.data !== e.data || o.rd !== e.rd || o.wid !== e.wid || o.err !== e.err) begin
                errors++;
                $display("FAIL bp_result: data=%h rd=%0d err=%b required data=%h rd=%0d err=%b",
                         o.data, o.rd, o.err, e.data, e.rd, e.err);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_wrap();
        res_t          e, o;
        logic [DW-1:0] want;
        want = {NT{32'hFFFF_FFFF}};
        send(2'd0, 0, 5'd0, {NT{32'd1}}, '0);
        send(2'd0, 0, 5'd0, {NT{32'd1}}, '0);
        send(2'd1, 0, 5'd11, {NT{32'hFFFF_FFFF}}, {NT{32'd1}});
        drain("wrap");
        checks++;
        if (obs_q.size() != 1) begin
            errors++;
            $display("FAIL wrap_count: got %0d results, required 1", obs_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (o.data !== want || o.data !== e.data || o.err !== 1'b0) begin
                errors++;
                $display("FAIL wrap_result: data=%h err=%b required data=%h err=0", o.data, o.err, want);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_isolation_clear();
        res_t e, o;
        for (int i = 0; i < 4; i++) send(2'd0, i % 2, 5'd0, rand_vec(), '0);
        for (int i = 0; i < 8; i++) send(2'd1, i % 2, 5'(i), rand_vec(), rand_vec());
        drain("iso");
        checks++;
        if (obs_q.size() != 8) begin
            errors++;
            $display("FAIL iso_count: got %0d results, required 8", obs_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (o.data !== e.data || o.rd !== e.rd || o.wid !== e.wid || o.err !== 1'b0) begin
                errors++;
                $display("FAIL iso_result: data=%h rd=%0d w=%0d err=%b required data=%h rd=%0d w=%0d err=0",
                         o.data, o.rd, o.wid, o.err, e.data, e.rd, e.wid);
            end
        end
        exp_q.delete(); obs_q.delete();
        send(2'd2, 0, 5'd0, '0, '0);
        checks++;
        if (b_ready_mask !== 2'b10) begin
            errors++;
            $display("FAIL clear_mask: b_ready_mask=%b required 10", b_ready_mask);
        end
        send(2'd1, 0, 5'd9, rand_vec(), rand_vec());
        drain("clear");
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (o.err !== 1'b1 || o.data !== e.data || o.rd !== 5'd9) begin
                errors++;
                $display("FAIL clear_result: err=%b data=%h rd=%0d required err=1 data=%h rd=9",
                         o.err, o.data, o.rd, e.data);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_back_to_back();
        res_t       e, o;
        int         sel;
        logic [1:0] op;
        rnd_stop = 1'b0;
        fork
            begin
                while (!rnd_stop) begin
                    @(negedge clk);
                    ready_out = ($urandom_range(0, 3) != 0);
                end
            end
        join_none
        for (int i = 0; i < 150; i++) begin
            sel = $urandom_range(0, 9);
            op  = (sel < 3) ? 2'd0 : (sel < 8) ? 2'd1 : (sel == 8) ? 2'd2 : 2'd3;
            send(op, $urandom_range(0, NW - 1), 5'($urandom_range(0, NR - 1)), rand_vec(), rand_vec());
        end
        rnd_stop = 1'b1;
        repeat (2) @(negedge clk);
        ready_out = 1'b1;
        drain("b2b");
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL b2b_count: got %0d results, required %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (o.data !== e.data || o.rd !== e.rd || o.wid !== e.wid || o.err !== e.err) begin
                errors++;
                $display("FAIL b2b_result: data=%h rd=%0d w=%0d err=%b required data=%h rd=%0d w=%0d err=%b",
                         o.data, o.rd, o.wid, o.err, e.data, e.rd, e.wid, e.err);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset_mid();
        ready_out = 1'b1;
        send(2'd0, 0, 5'd0, rand_vec(), '0);
        send(2'd0, 0, 5'd0, rand_vec(), '0);
        for (int i = 0; i < 3; i++) send(2'd1, i % 2, 5'(20 + i), rand_vec(), rand_vec());
        checks++;
        if (valid_out !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_inflight: valid_out=%b required 1", valid_out);
        end
        #1;
        reset = 1'b1;
        model_reset();
        #1;
        checks++;
        if (valid_out !== 1'b0 || b_ready_mask !== 2'b00) begin
            errors++;
            $display("FAIL reset_mid_async: valid_out=%b mask=%b required 0/00", valid_out, b_ready_mask);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        #3;
        checks++;
        if (obs_q.size() != 0 || valid_out !== 1'b0 || b_ready_mask !== 2'b00) begin
            errors++;
            $display("FAIL reset_mid_flush: results=%0d valid_out=%b mask=%b required 0/0/00",
                     obs_q.size(), valid_out, b_ready_mask);
        end
        obs_q.delete();
    endtask

    initial begin
        reset = 1'b1;
        test_reset();
        test_load_mma();
        test_incomplete();
        test_backpressure();
        test_wrap();
        test_isolation_clear();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
